// File: rtl/ooo_hazard_ctrl_pkg.sv
// rtl/ooo_hazard_ctrl_pkg.sv - shared types and constants for the hazard/control block
package ooo_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FU_AU = 2'd0,
        FU_MU = 2'd1,
        FU_DU = 2'd2,
        FU_LS = 2'd3
    } scalar_fu_t;

    typedef enum logic [2:0] {
        HZ_RUN      = 3'd0,
        HZ_TRAP     = 3'd1,
        HZ_IFENCE_D = 3'd2,
        HZ_IFENCE_I = 3'd3,
        HZ_HALTED   = 3'd4
    } hz_state_t;

    localparam int REDIRECT_MAX = 4;
    localparam int REDIRECT_CNT_W = 2;

endpackage

// File: rtl/ooo_stall_decode.sv
// rtl/ooo_stall_decode.sv - structural stall decode from decode-stage FU type and FU busy flags
module ooo_stall_decode
    import ooo_hazard_ctrl_pkg::*;
(
    input  scalar_fu_t fu_type,
    input  logic       busy_au,
    input  logic       busy_mu,
    input  logic       busy_du,
    input  logic       busy_ls,
    input  logic       rob_full,
    input  logic       data_hazard,
    input  logic       i_mem_busy,
    input  logic       d_mem_busy,
    output logic       stall_au,
    output logic       stall_mu,
    output logic       stall_du,
    output logic       stall_ls,
    output logic       stall_all,
    output logic       stall_any
);

    assign stall_au  = busy_au & (fu_type == FU_AU);
    assign stall_mu  = busy_mu & (fu_type == FU_MU);
    assign stall_du  = busy_du & (fu_type == FU_DU);
    assign stall_ls  = busy_ls & (fu_type == FU_LS);
    assign stall_all = rob_full | data_hazard | i_mem_busy | d_mem_busy;
    assign stall_any = stall_all | stall_au | stall_mu | stall_du | stall_ls;

endmodule

// File: rtl/ooo_hazard_ctrl.sv
// rtl/ooo_hazard_ctrl.sv - stall/flush/redirect control with trap, fence.i and halt sequencing
module ooo_hazard_ctrl
    import ooo_hazard_ctrl_pkg::*;
#(
    parameter int WORD_W          = 32,
    parameter int REDIRECT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_mem_busy,
    input  logic              d_mem_busy,
    input  logic              dren,
    input  logic              dwen,
    input  scalar_fu_t        fu_type,
    input  logic              busy_au,
    input  logic              busy_mu,
    input  logic              busy_du,
    input  logic              busy_ls,
    input  logic              data_hazard,
    input  logic              rob_full,
    input  logic              mispredict,
    input  logic              halt,
    input  logic              ifence,
    input  logic              dflushed,
    input  logic              iflushed,
    input  logic              exc_any,
    input  logic              intr_taken,
    input  logic              ret,
    input  logic [WORD_W-1:0] priv_pc_in,
    output logic              pc_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              ex_comm_flush,
    output logic              npc_sel,
    output logic              stall_au,
    output logic              stall_mu,
    output logic              stall_du,
    output logic              stall_ls,
    output logic              stall_all,
    output logic              stall,
    output logic              ifence_flush,
    output logic              insert_priv_pc,
    output logic [WORD_W-1:0] priv_pc,
    output logic              iren,
    output logic              dmem_access,
    output logic              halted
);

    localparam logic [REDIRECT_CNT_W-1:0] CNT_INIT = REDIRECT_CNT_W'(REDIRECT_CYCLES - 1);

    hz_state_t                 state_q, state_d;
    logic [REDIRECT_CNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0]         priv_pc_q, priv_pc_d;

    logic dec_au, dec_mu, dec_du, dec_ls, dec_all, dec_any;
    logic trap_req;

    ooo_stall_decode u_stall_decode (
        .fu_type     (fu_type),
        .busy_au     (busy_au),
        .busy_mu     (busy_mu),
        .busy_du     (busy_du),
        .busy_ls     (busy_ls),
        .rob_full    (rob_full),
        .data_hazard (data_hazard),
        .i_mem_busy  (i_mem_busy),
        .d_mem_busy  (d_mem_busy),
        .stall_au    (dec_au),
        .stall_mu    (dec_mu),
        .stall_du    (dec_du),
        .stall_ls    (dec_ls),
        .stall_all   (dec_all),
        .stall_any   (dec_any)
    );

    assign trap_req = exc_any | intr_taken | ret;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= HZ_RUN;
            cnt_q     <= '0;
            priv_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            priv_pc_q <= priv_pc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        priv_pc_d      = priv_pc_q;
        pc_en          = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        ex_comm_flush  = 1'b0;
        npc_sel        = 1'b0;
        stall_au       = 1'b0;
        stall_mu       = 1'b0;
        stall_du       = 1'b0;
        stall_ls       = 1'b0;
        stall_all      = 1'b0;
        stall          = 1'b0;
        ifence_flush   = 1'b0;
        insert_priv_pc = 1'b0;
        iren           = 1'b1;
        halted         = 1'b0;

        // Any trap outside HALTED (re)starts the redirect with a fresh target.
        if (trap_req && state_q != HZ_HALTED) begin
            state_d   = HZ_TRAP;
            cnt_d     = CNT_INIT;
            priv_pc_d = priv_pc_in;
        end

        case (state_q)
            HZ_RUN: begin
                stall_au  = dec_au;
                stall_mu  = dec_mu;
                stall_du  = dec_du;
                stall_ls  = dec_ls;
                stall_all = dec_all;
                stall     = dec_any;
                pc_en     = ~dec_any;
                if (!trap_req) begin
                    if (mispredict) begin
                        npc_sel     = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ifence) begin
                        state_d = HZ_IFENCE_D;
                    end else if (halt) begin
                        state_d = HZ_HALTED;
                    end
                end
            end
            HZ_TRAP: begin
                insert_priv_pc = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                ex_mem_flush   = 1'b1;
                ex_comm_flush  = 1'b1;
                pc_en          = (cnt_q == '0);
                if (!trap_req) begin
                    if (cnt_q == '0) begin
                        state_d = HZ_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            HZ_IFENCE_D: begin
                ifence_flush = 1'b1;
                if (!trap_req && dflushed) begin
                    if (iflushed) begin
                        state_d     = HZ_RUN;
                        if_id_flush = 1'b1;
                    end else begin
                        state_d = HZ_IFENCE_I;
                    end
                end
            end
            HZ_IFENCE_I: begin
                ifence_flush = 1'b1;
                if (!trap_req && iflushed) begin
                    state_d     = HZ_RUN;
                    if_id_flush = 1'b1;
                end
            end
            HZ_HALTED: begin
                iren   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    assign dmem_access = (dren | dwen) & ~ex_mem_flush & (state_q != HZ_HALTED);
    assign priv_pc     = priv_pc_q;

endmodule

// File: tb/tb_ooo_hazard_ctrl.sv
// tb/tb_ooo_hazard_ctrl.sv - directed self-checking bench for ooo_hazard_ctrl
module tb_ooo_hazard_ctrl;
    import ooo_hazard_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_mem_busy, d_mem_busy, dren, dwen;
    scalar_fu_t  fu_type;
    logic        busy_au, busy_mu, busy_du, busy_ls;
    logic        data_hazard, rob_full, mispredict, halt, ifence;
    logic        dflushed, iflushed, exc_any, intr_taken, ret;
    logic [31:0] priv_pc_in;
    logic        pc_en, if_id_flush, id_ex_flush, ex_mem_flush, ex_comm_flush, npc_sel;
    logic        stall_au, stall_mu, stall_du, stall_ls, stall_all, stall;
    logic        ifence_flush, insert_priv_pc, iren, dmem_access, halted;
    logic [31:0] priv_pc;

    int total = 0;
    int bad = 0;
    logic done = 1'b0;

    always #5 CLK = ~CLK;

    ooo_hazard_ctrl #(.WORD_W(32), .REDIRECT_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST),
        .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy),
        .dren(dren), .dwen(dwen), .fu_type(fu_type),
        .busy_au(busy_au), .busy_mu(busy_mu), .busy_du(busy_du), .busy_ls(busy_ls),
        .data_hazard(data_hazard), .rob_full(rob_full), .mispredict(mispredict),
        .halt(halt), .ifence(ifence), .dflushed(dflushed), .iflushed(iflushed),
        .exc_any(exc_any), .intr_taken(intr_taken), .ret(ret), .priv_pc_in(priv_pc_in),
        .pc_en(pc_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .ex_comm_flush(ex_comm_flush), .npc_sel(npc_sel),
        .stall_au(stall_au), .stall_mu(stall_mu), .stall_du(stall_du), .stall_ls(stall_ls),
        .stall_all(stall_all), .stall(stall), .ifence_flush(ifence_flush),
        .insert_priv_pc(insert_priv_pc), .priv_pc(priv_pc), .iren(iren),
        .dmem_access(dmem_access), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_mem_busy = 0; d_mem_busy = 0; dren = 0; dwen = 0; fu_type = FU_AU;
        busy_au = 0; busy_mu = 0; busy_du = 0; busy_ls = 0;
        data_hazard = 0; rob_full = 0; mispredict = 0; halt = 0; ifence = 0;
        dflushed = 0; iflushed = 0; exc_any = 0; intr_taken = 0; ret = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        if (!done) begin
            bad++;
            $error("FAIL timeout waiting for stimulus to complete");
            $finish;
        end
    end

    initial begin
        idle();
        priv_pc_in = 32'h0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst_pc_en", pc_en, 1'b1);
        chk("rst_iren", iren, 1'b1);
        chk("rst_priv_pc", priv_pc, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_insert", insert_priv_pc, 1'b0);

        priv_pc_in = 32'h0000_0100; exc_any = 1; mispredict = 1;
        #1;
        chk("trap_vs_mp_npc_sel", npc_sel, 1'b0);
        chk("trap_vs_mp_if_id", if_id_flush, 1'b0);
        tick();
        exc_any = 0; mispredict = 0; priv_pc_in = 32'h0000_0200; dren = 1;
        #1;
        chk("trap1_insert", insert_priv_pc, 1'b1);
        chk("trap1_flushes", {if_id_flush, id_ex_flush, ex_mem_flush, ex_comm_flush}, 4'hf);
        chk("trap1_priv_pc", priv_pc, 32'h100);
        chk("trap1_pc_en", pc_en, 1'b0);
        chk("trap1_dmem", dmem_access, 1'b0);
        tick();
        chk("trap2_insert", insert_priv_pc, 1'b1);
        chk("trap2_flushes", {if_id_flush, id_ex_flush, ex_mem_flush, ex_comm_flush}, 4'hf);
        chk("trap2_pc_en", pc_en, 1'b1);
        tick();
        chk("trap_done_insert", insert_priv_pc, 1'b0);
        chk("trap_done_flush", ex_comm_flush, 1'b0);
        chk("trap_done_pc_en", pc_en, 1'b1);
        chk("trap_done_priv_pc", priv_pc, 32'h100);
        chk("run_dmem", dmem_access, 1'b1);
        dren = 0;

        mispredict = 1;
        #1;
        chk("mp_flushes", {npc_sel, if_id_flush, id_ex_flush, ex_mem_flush}, 4'he);
        tick();
        mispredict = 0;
        #1;
        chk("mp_after_npc_sel", npc_sel, 1'b0);
        chk("mp_after_pc_en", pc_en, 1'b1);

        ifence = 1;
        #1;
        chk("ifence_req_cycle", ifence_flush, 1'b0);
        tick();
        ifence = 0;
        for (int c = 1; c <= 6; c++) begin
            dflushed = (c == 3);
            iflushed = (c == 6);
            #1;
            chk("ifence_flush_seq", ifence_flush, 1'b1);
            chk("ifence_pc_en_seq", pc_en, 1'b0);
            chk("ifence_exit_if_id", if_id_flush, (c == 6));
            tick();
        end
        dflushed = 0; iflushed = 0;
        #1;
        chk("ifence_done_flush", ifence_flush, 1'b0);
        chk("ifence_done_pc_en", pc_en, 1'b1);
        chk("ifence_done_if_id", if_id_flush, 1'b0);

        ifence = 1;
        tick();
        ifence = 0; dflushed = 1; iflushed = 1;
        #1;
        chk("ifence_direct_if_id", if_id_flush, 1'b1);
        chk("ifence_direct_flush", ifence_flush, 1'b1);
        tick();
        dflushed = 0; iflushed = 0;
        #1;
        chk("ifence_direct_run", ifence_flush, 1'b0);
        chk("ifence_direct_pc_en", pc_en, 1'b1);

        ifence = 1;
        tick();
        ifence = 0;
        #1;
        chk("mid_ifence_flush", ifence_flush, 1'b1);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst2_ifence_flush", ifence_flush, 1'b0);
        chk("rst2_pc_en", pc_en, 1'b1);
        chk("rst2_iren", iren, 1'b1);
        chk("rst2_priv_pc", priv_pc, 32'h0);

        fu_type = FU_MU; busy_mu = 1;
        #1;
        chk("mu_stall_mu", stall_mu, 1'b1);
        chk("mu_stall", stall, 1'b1);
        chk("mu_pc_en", pc_en, 1'b0);
        chk("mu_stall_all", stall_all, 1'b0);
        busy_mu = 0; busy_du = 1; fu_type = FU_AU;
        #1;
        chk("du_wrong_fu", stall_du, 1'b0);
        chk("du_wrong_fu_pc_en", pc_en, 1'b1);
        fu_type = FU_DU;
        #1;
        chk("du_right_fu", stall_du, 1'b1);
        busy_du = 0; rob_full = 1;
        #1;
        chk("rob_stall_all", stall_all, 1'b1);
        chk("rob_stall", stall, 1'b1);
        chk("rob_pc_en", pc_en, 1'b0);
        rob_full = 0;

        halt = 1;
        tick();
        halt = 0; exc_any = 1; priv_pc_in = 32'h300; dren = 1;
        #1;
        chk("halt_halted", halted, 1'b1);
        chk("halt_iren", iren, 1'b0);
        chk("halt_pc_en", pc_en, 1'b0);
        chk("halt_dmem", dmem_access, 1'b0);
        tick();
        chk("halt_trap_insert", insert_priv_pc, 1'b0);
        chk("halt_persist", halted, 1'b1);
        chk("halt_priv_pc", priv_pc, 32'h0);
        exc_any = 0; dren = 0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("unhalt_halted", halted, 1'b0);
        chk("unhalt_iren", iren, 1'b1);
        chk("unhalt_pc_en", pc_en, 1'b1);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
